// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: packed control layout, control bit positions,
// the ID/EX stage state enumeration and a small control decode helper.
package pipe_pkg;

   // Packed control word: {MemRead,MemWrite,RegWrite,MemtoReg,ALUSrc,ALUOp[2:0]}
   localparam int CTRLW          = 8;
   localparam int CTRL_MEMREAD   = 7;
   localparam int CTRL_MEMWRITE  = 6;
   localparam int CTRL_REGWRITE  = 5;
   localparam int CTRL_MEMTOREG  = 4;
   localparam int CTRL_ALUSRC    = 3;
   localparam int CTRL_ALUOP_MSB = 2;
   localparam int CTRL_ALUOP_LSB = 0;

   // Occupancy of the ID/EX register
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      BUBBLE = 2'd2
   } stage_state_e;

   // True when the control word describes a load
   function automatic logic is_load(input logic [CTRLW-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage : pipe_pkg

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector for the ID/EX stage.
// Flags a hazard when the instruction held in ID/EX is a load to a non-zero
// register that the valid instruction currently in ID reads as RS or RT.
module id_ex_hazard
   import pipe_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic          held_mem_read,
   input  logic [AW-1:0] held_rd_addr,
   input  logic          id_valid,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic          hazard
);

   // Pure compare: load held, destination non-zero, and ID reads that destination
   always_comb begin
      hazard = held_mem_read
             && (held_rd_addr != '0)
             && id_valid
             && ((held_rd_addr == rs_addr) || (held_rd_addr == rt_addr));
   end

endmodule : id_ex_hazard

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake towards EX.
// Captures operands straight from the register file read ports, inserts a
// one-cycle NOP bubble behind a load whose result the next ID instruction
// needs, and clears on flush_i.
// Optional build macro ID_EX_WB_BYPASS_EN: forwards the WB write data into the
// captured RS/RT operands (on accept, and into a held stalled payload).
// Without it the register file must provide write-before-read behaviour.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             id_valid_i,
   output logic             id_ready_o,
   input  logic [AW-1:0]    rs_addr_i,
   input  logic [AW-1:0]    rt_addr_i,
   input  logic [AW-1:0]    rd_addr_i,
   input  logic [DW-1:0]    rs_data_i,
   input  logic [DW-1:0]    rt_data_i,
   input  logic [DW-1:0]    imm_i,
   input  logic [CTRLW-1:0] ctrl_i,
   input  logic             wb_we_i,
   input  logic [AW-1:0]    wb_addr_i,
   input  logic [DW-1:0]    wb_data_i,
   output logic             ex_valid_o,
   input  logic             ex_ready_i,
   output logic [DW-1:0]    ex_rs_data_o,
   output logic [DW-1:0]    ex_rt_data_o,
   output logic [DW-1:0]    ex_imm_o,
   output logic [AW-1:0]    ex_rs_addr_o,
   output logic [AW-1:0]    ex_rt_addr_o,
   output logic [AW-1:0]    ex_rd_addr_o,
   output logic [CTRLW-1:0] ex_ctrl_o,
   output logic             hazard_o
);

   stage_state_e     state_q, state_d;

   logic [DW-1:0]    rs_data_q, rt_data_q, imm_q;
   logic [AW-1:0]    rs_addr_q, rt_addr_q, rd_addr_q;
   logic [CTRLW-1:0] ctrl_q;

   logic             hazard;
   logic             accept;       // ID -> stage transfer this cycle
   logic             drain;        // stage -> EX transfer this cycle
   logic             load_bubble;  // held load leaves and a NOP takes its place
   logic [DW-1:0]    rs_operand, rt_operand;
   logic             rs_refresh, rt_refresh;

   id_ex_hazard #(
      .AW(AW)
   ) u_hazard (
      .held_mem_read (is_load(ctrl_q)),
      .held_rd_addr  (rd_addr_q),
      .id_valid      (id_valid_i),
      .rs_addr       (rs_addr_i),
      .rt_addr       (rt_addr_i),
      .hazard        (hazard)
   );

   assign ex_valid_o = (state_q != EMPTY);
   assign id_ready_o = !hazard && (!ex_valid_o || ex_ready_i);
   assign accept     = id_valid_i && id_ready_o;
   assign drain      = ex_valid_o && ex_ready_i;
   assign hazard_o   = hazard;

   // Operand values to capture: register 0 always reads as zero, optional WB bypass
   always_comb begin
      rs_operand = rs_data_i;
      rt_operand = rt_data_i;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs_addr_i)) rs_operand = wb_data_i;
      if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rt_addr_i)) rt_operand = wb_data_i;
`endif
      if (rs_addr_i == '0) rs_operand = '0;
      if (rt_addr_i == '0) rt_operand = '0;
   end

`ifdef ID_EX_WB_BYPASS_EN
   // A WB write landing on a register the stalled payload reads replaces its stale operand
   always_comb begin
      rs_refresh = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs_addr_q);
      rt_refresh = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rt_addr_q);
   end
`else
   // Without the bypass the WB port is only observed by the register file itself
   logic unused_wb;
   assign unused_wb  = ^{wb_we_i, wb_addr_i, wb_data_i};
   assign rs_refresh = 1'b0;
   assign rt_refresh = 1'b0;
`endif

   // Next-state decode; flush overrides every other transition
   always_comb begin
      // NOTE: each signal driven here gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      state_d     = state_q;
      load_bubble = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (drain) begin
               if (hazard) begin
                  state_d     = BUBBLE;
                  load_bubble = 1'b1;
               end else if (accept) begin
                  state_d = FULL;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         BUBBLE: begin
            if (drain) state_d = accept ? FULL : EMPTY;
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d     = EMPTY;
         load_bubble = 1'b0;
      end
   end

   // Stage occupancy register
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state is written with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_i) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Payload register: capture on accept, zero for the bubble, clear control when not FULL
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: the data fields are reset as well as control, so nothing from
         // before reset is ever visible on the ex_* outputs.
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
         ctrl_q    <= '0;
      end else if (flush_i) begin
         ctrl_q <= '0;
      end else if (accept) begin
         rs_data_q <= rs_operand;
         rt_data_q <= rt_operand;
         imm_q     <= imm_i;
         rs_addr_q <= rs_addr_i;
         rt_addr_q <= rt_addr_i;
         rd_addr_q <= rd_addr_i;
         ctrl_q    <= ctrl_i;
      end else if (load_bubble) begin
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
         ctrl_q    <= '0;
      end else if (drain) begin
         ctrl_q <= '0;
      end else if (state_q == FULL) begin
         if (rs_refresh) rs_data_q <= wb_data_i;
         if (rt_refresh) rt_data_q <= wb_data_i;
      end
   end

   // ctrl_q is only non-zero while FULL, so the NOP/empty encoding needs no extra gating
   assign ex_rs_data_o = rs_data_q;
   assign ex_rt_data_o = rt_data_q;
   assign ex_imm_o     = imm_q;
   assign ex_rs_addr_o = rs_addr_q;
   assign ex_rt_addr_o = rt_addr_q;
   assign ex_rd_addr_o = rd_addr_q;
   assign ex_ctrl_o    = ctrl_q;

endmodule : id_ex_stage
